// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - trap controller state/kind encodings and latched trap context type
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE     = 2'd0,
    TRAP_FLUSH    = 2'd1,
    TRAP_REDIRECT = 2'd2
  } trap_state_e;

  typedef enum logic {
    KIND_EX   = 1'b0,
    KIND_ERTN = 1'b1
  } trap_kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
  } trap_ctx_t;

  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - exception/ERTN flush and fetch-redirect sequencer between WB, CSR file and IF
// Optional perf counters (ex_count/ertn_count) under TRAP_CTRL_PERF_CNT_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        redirect_ready,
  output logic        ex_commit,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_ecode,
  output logic [8:0]  ex_esubcode,
  output logic        ertn_commit,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
`ifdef TRAP_CTRL_PERF_CNT_EN
  output logic [31:0] ex_count,
  output logic [31:0] ertn_count,
`endif
  output logic        drop_err
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CYCLES[FLUSH_CNT_W-1:0];
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

  trap_state_e              state_q, state_d;
  trap_kind_e               kind_q;
  logic [FLUSH_CNT_W-1:0]   cnt_q;
  logic [31:0]              target_q;
  trap_ctx_t                ctx_q;
  logic                     drop_err_q;
  logic                     event_in;
  logic                     accept;

  assign event_in = wb_ex | ertn_flush;
  assign accept   = (state_q == TRAP_IDLE) && event_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TRAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TRAP_IDLE:     if (event_in)           state_d = TRAP_FLUSH;
      TRAP_FLUSH:    if (cnt_q == FLUSH_LAST) state_d = TRAP_REDIRECT;
      TRAP_REDIRECT: if (redirect_ready)     state_d = TRAP_IDLE;
      default:                               state_d = TRAP_IDLE;
    endcase
  end

  // Exception has priority; a simultaneous ERTN is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      kind_q   <= KIND_EX;
      target_q <= '0;
      ctx_q    <= '0;
    end else if (accept) begin
      cnt_q    <= CNT_ONE;
      kind_q   <= wb_ex ? KIND_EX : KIND_ERTN;
      target_q <= wb_ex ? csr_eentry : csr_era;
      if (wb_ex) begin
        ctx_q <= '{pc: wb_pc, ecode: wb_ecode, esubcode: wb_esubcode};
      end
    end else if (state_q == TRAP_FLUSH) begin
      cnt_q <= (cnt_q == FLUSH_LAST) ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_q <= 1'b0;
    end else if ((state_q != TRAP_IDLE) && event_in) begin
      drop_err_q <= 1'b1;
    end
  end

  // Commit pulses fire on the first FLUSH cycle only (counter still 1).
  always_comb begin
    ex_commit      = 1'b0;
    ertn_commit    = 1'b0;
    flush_all      = 1'b0;
    busy           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      TRAP_FLUSH: begin
        flush_all   = 1'b1;
        busy        = 1'b1;
        ex_commit   = (cnt_q == CNT_ONE) && (kind_q == KIND_EX);
        ertn_commit = (cnt_q == CNT_ONE) && (kind_q == KIND_ERTN);
      end
      TRAP_REDIRECT: begin
        flush_all      = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  assign ex_pc       = ctx_q.pc;
  assign ex_ecode    = ctx_q.ecode;
  assign ex_esubcode = ctx_q.esubcode;
  assign drop_err    = drop_err_q;

`ifdef TRAP_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_count   <= '0;
      ertn_count <= '0;
    end else begin
      if (ex_commit)   ex_count   <= ex_count + 32'd1;
      if (ertn_commit) ertn_count <= ertn_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl, instances at FLUSH_CYCLES 1 (a) and 3 (b)
`timescale 1ns/1ps
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_ex, ertn_flush, redirect_ready;
  logic [31:0] wb_pc, csr_eentry, csr_era;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;

  logic        a_ex_commit, a_ertn_commit, a_flush_all, a_redirect_valid, a_busy, a_drop_err;
  logic [31:0] a_ex_pc, a_redirect_pc;
  logic [5:0]  a_ex_ecode;
  logic [8:0]  a_ex_esubcode;
  logic        b_ex_commit, b_ertn_commit, b_flush_all, b_redirect_valid, b_busy, b_drop_err;
  logic [31:0] b_ex_pc, b_redirect_pc;
  logic [5:0]  b_ex_ecode;
  logic [8:0]  b_ex_esubcode;
`ifdef TRAP_CTRL_PERF_CNT_EN
  logic [31:0] a_ex_count, a_ertn_count, b_ex_count, b_ertn_count;
`endif

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } exp_commit_t;

  exp_commit_t qc_a[$], qc_b[$];
  logic [31:0] qr_a[$], qr_b[$];
  int checks = 0;
  int errors = 0;
  int exp_ex_n = 0;
  int exp_ertn_n = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .redirect_ready(redirect_ready), .ex_commit(a_ex_commit), .ex_pc(a_ex_pc),
    .ex_ecode(a_ex_ecode), .ex_esubcode(a_ex_esubcode), .ertn_commit(a_ertn_commit),
    .flush_all(a_flush_all), .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .busy(a_busy),
`ifdef TRAP_CTRL_PERF_CNT_EN
    .ex_count(a_ex_count), .ertn_count(a_ertn_count),
`endif
    .drop_err(a_drop_err)
  );

  trap_ctrl #(.FLUSH_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .redirect_ready(redirect_ready), .ex_commit(b_ex_commit), .ex_pc(b_ex_pc),
    .ex_ecode(b_ex_ecode), .ex_esubcode(b_ex_esubcode), .ertn_commit(b_ertn_commit),
    .flush_all(b_flush_all), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .busy(b_busy),
`ifdef TRAP_CTRL_PERF_CNT_EN
    .ex_count(b_ex_count), .ertn_count(b_ertn_count),
`endif
    .drop_err(b_drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one event for a cycle; the bench's own priority model decides what to expect.
  task automatic ev(input logic ex, input logic ertn, input logic [31:0] pc, input logic [5:0] ec,
                    input logic [8:0] es, input logic [31:0] eentry, input logic [31:0] era,
                    input bit redir);
    exp_commit_t e;
    wb_ex = ex; ertn_flush = ertn; wb_pc = pc; wb_ecode = ec; wb_esubcode = es;
    csr_eentry = eentry; csr_era = era;
    e.kind = ex ? 1'b0 : 1'b1;
    e.pc = pc; e.ecode = ec; e.esub = es;
    qc_a.push_back(e);
    qc_b.push_back(e);
    if (redir) begin
      qr_a.push_back(ex ? eentry : era);
      qr_b.push_back(ex ? eentry : era);
    end
    if (ex) exp_ex_n++; else exp_ertn_n++;
    tick();
    wb_ex = 1'b0;
    ertn_flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((a_busy || b_busy) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, a_busy, b_busy}, 32'd0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_commit_t e;
    if (rst) begin
      if (a_ex_commit || a_ertn_commit) begin
        chk("a_commit_expected", {31'd0, qc_a.size() != 0}, 32'd1);
        if (qc_a.size() != 0) begin
          e = qc_a.pop_front();
          chk("a_ex_commit_kind", {31'd0, a_ex_commit}, {31'd0, ~e.kind});
          chk("a_ertn_commit_kind", {31'd0, a_ertn_commit}, {31'd0, e.kind});
          if (!e.kind) begin
            chk("a_ex_pc", a_ex_pc, e.pc);
            chk("a_ex_ecode", {26'd0, a_ex_ecode}, {26'd0, e.ecode});
            chk("a_ex_esubcode", {23'd0, a_ex_esubcode}, {23'd0, e.esub});
          end
        end
      end
      if (a_redirect_valid && redirect_ready) begin
        chk("a_redirect_expected", {31'd0, qr_a.size() != 0}, 32'd1);
        if (qr_a.size() != 0) chk("a_redirect_pc", a_redirect_pc, qr_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_commit_t e;
    if (rst) begin
      if (b_ex_commit || b_ertn_commit) begin
        chk("b_commit_expected", {31'd0, qc_b.size() != 0}, 32'd1);
        if (qc_b.size() != 0) begin
          e = qc_b.pop_front();
          chk("b_ex_commit_kind", {31'd0, b_ex_commit}, {31'd0, ~e.kind});
          chk("b_ertn_commit_kind", {31'd0, b_ertn_commit}, {31'd0, e.kind});
          if (!e.kind) begin
            chk("b_ex_pc", b_ex_pc, e.pc);
            chk("b_ex_ecode", {26'd0, b_ex_ecode}, {26'd0, e.ecode});
            chk("b_ex_esubcode", {23'd0, b_ex_esubcode}, {23'd0, e.esub});
          end
        end
      end
      if (b_redirect_valid && redirect_ready) begin
        chk("b_redirect_expected", {31'd0, qr_b.size() != 0}, 32'd1);
        if (qr_b.size() != 0) chk("b_redirect_pc", b_redirect_pc, qr_b.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0; redirect_ready = 1'b1;
    wb_pc = '0; wb_ecode = '0; wb_esubcode = '0; csr_eentry = '0; csr_era = '0;
    repeat (2) tick();
    chk("reset_a_ctrl", {26'd0, a_ex_commit, a_ertn_commit, a_flush_all, a_redirect_valid, a_busy, a_drop_err}, 32'd0);
    chk("reset_a_ex_pc", a_ex_pc, 32'd0);
    chk("reset_a_codes", {17'd0, a_ex_ecode, a_ex_esubcode}, 32'd0);
    chk("reset_a_redirect_pc", a_redirect_pc, 32'd0);
    rst = 1'b1;
    tick();

    // Exception, FLUSH_CYCLES=1 timing on instance a
    ev(1'b1, 1'b0, 32'h1c000010, 6'h0b, 9'h000, 32'h1c008000, 32'h0, 1'b1);
    chk("ex_t1_commit", {31'd0, a_ex_commit}, 32'd1);
    chk("ex_t1_ex_pc", a_ex_pc, 32'h1c000010);
    chk("ex_t1_ecode", {26'd0, a_ex_ecode}, 32'h0b);
    chk("ex_t1_flush_busy_valid", {29'd0, a_flush_all, a_busy, a_redirect_valid}, 32'b110);
    chk("ex_t1_b_commit", {31'd0, b_ex_commit}, 32'd1);
    tick();
    chk("ex_t2_valid", {31'd0, a_redirect_valid}, 32'd1);
    chk("ex_t2_redirect_pc", a_redirect_pc, 32'h1c008000);
    chk("ex_t2_commit_gone", {31'd0, a_ex_commit}, 32'd0);
    chk("ex_t2_ex_pc_kept", a_ex_pc, 32'h1c000010);
    chk("ex_t2_b_flush_no_valid", {30'd0, b_flush_all, b_redirect_valid}, 32'b10);
    tick();
    chk("ex_t3_idle", {29'd0, a_busy, a_flush_all, a_redirect_valid}, 32'd0);
    wait_idle("ex_idle_timeout");

    // ERTN with IF stalling for three cycles
    redirect_ready = 1'b0;
    ev(1'b0, 1'b1, 32'h0, 6'h0, 9'h0, 32'h1c008000, 32'h1c000014, 1'b1);
    chk("ertn_t1_commit", {30'd0, a_ertn_commit, a_ex_commit}, 32'b10);
    chk("ertn_t1_b_commit", {31'd0, b_ertn_commit}, 32'd1);
    chk("ertn_ex_pc_unchanged", a_ex_pc, 32'h1c000010);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ertn_stall_valid", {31'd0, a_redirect_valid}, 32'd1);
      chk("ertn_stall_pc", a_redirect_pc, 32'h1c000014);
      tick();
    end
    redirect_ready = 1'b1;
    chk("ertn_hs_valid", {31'd0, a_redirect_valid}, 32'd1);
    chk("ertn_hs_pc", a_redirect_pc, 32'h1c000014);
    tick();
    chk("ertn_after_hs", {29'd0, a_redirect_valid, a_flush_all, a_busy}, 32'd0);
    wait_idle("ertn_idle_timeout");

    // Simultaneous exception and ERTN
    ev(1'b1, 1'b1, 32'h1c000020, 6'h08, 9'h005, 32'h1c00a000, 32'h1c000030, 1'b1);
    chk("simul_commit", {30'd0, a_ex_commit, a_ertn_commit}, 32'b10);
    wait_idle("simul_idle_timeout");
    chk("simul_no_drop", {30'd0, a_drop_err, b_drop_err}, 32'd0);

    // Event arriving while busy is dropped
    ev(1'b1, 1'b0, 32'h1c000040, 6'h0e, 9'h003, 32'h1c00c000, 32'h0, 1'b1);
    wb_ex = 1'b1; wb_pc = 32'h1c000099; wb_ecode = 6'h3f; csr_eentry = 32'h1c0dead0;
    tick();
    wb_ex = 1'b0;
    chk("busy_target_kept", a_redirect_pc, 32'h1c00c000);
    chk("busy_ex_pc_kept", a_ex_pc, 32'h1c000040);
    chk("busy_drop_err", {30'd0, a_drop_err, b_drop_err}, 32'b11);
    wait_idle("busy_idle_timeout");
    chk("drop_err_sticky", {30'd0, a_drop_err, b_drop_err}, 32'b11);

    // Asynchronous reset in the second FLUSH cycle of instance b
    ev(1'b1, 1'b0, 32'h1c000050, 6'h01, 9'h000, 32'h1c00e000, 32'h0, 1'b0);
    tick();
    chk("pre_reset_b_flush", {31'd0, b_flush_all}, 32'd1);
    #2;
    rst = 1'b0;
    exp_ex_n = 0;
    exp_ertn_n = 0;
    #1;
    chk("mid_reset_b_ctrl", {26'd0, b_ex_commit, b_ertn_commit, b_flush_all, b_redirect_valid, b_busy, b_drop_err}, 32'd0);
    chk("mid_reset_b_ex_pc", b_ex_pc, 32'd0);
    chk("mid_reset_b_redirect_pc", b_redirect_pc, 32'd0);
    chk("mid_reset_a_ctrl", {29'd0, a_flush_all, a_busy, a_drop_err}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_reset_idle", {29'd0, b_busy, b_ex_commit, b_ertn_commit}, 32'd0);
    ev(1'b1, 1'b0, 32'h1c000060, 6'h02, 9'h1ff, 32'h1c008000, 32'h0, 1'b1);
    chk("post_reset_commit", {31'd0, b_ex_commit}, 32'd1);
    chk("post_reset_esub", {23'd0, b_ex_esubcode}, 32'h1ff);
    wait_idle("post_reset_idle_timeout");

    // Two more exceptions and two ERTNs
    for (int i = 0; i < 4; i++) begin
      ev(i[0] == 1'b0, i[0] == 1'b1, 32'h1c000100 + 32'(i * 4), 6'(i + 4), 9'(i * 7),
         32'h1c010000 + 32'(i * 16), 32'h1c020000 + 32'(i * 16), 1'b1);
      wait_idle("loop_idle_timeout");
    end
`ifdef TRAP_CTRL_PERF_CNT_EN
    chk("perf_a_ex_count", a_ex_count, 32'(exp_ex_n));
    chk("perf_a_ertn_count", a_ertn_count, 32'(exp_ertn_n));
    chk("perf_b_ex_count", b_ex_count, 32'(exp_ex_n));
    chk("perf_b_ertn_count", b_ertn_count, 32'(exp_ertn_n));
`endif
    repeat (2) tick();
    chk("qc_a_drained", 32'(qc_a.size()), 32'd0);
    chk("qc_b_drained", 32'(qc_b.size()), 32'd0);
    chk("qr_a_drained", 32'(qr_a.size()), 32'd0);
    chk("qr_b_drained", 32'(qr_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences pipeline flush and fetch redirect when WB reports an exception (wb_ex) or ERTN (ertn_flush).
- Latches the trap context and emits one-cycle commit pulses to the CSR file (ERA/ESTAT/CRMD update).
- Flushes all stages, then hands the target PC to IF through a valid/ready handshake.
- Sits between WB, the CSR file and IF.

Parameters:
- FLUSH_CYCLES, 1, cycles flush_all is held in FLUSH before redirect; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- wb_ex  in  1  exception retiring in WB
- ertn_flush  in  1  ERTN retiring in WB
- wb_pc  in  32  PC of the WB instruction
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- csr_eentry  in  32  current EENTRY value
- csr_era  in  32  current ERA value
- redirect_ready  in  1  IF accepts redirect
- ex_commit  out  1  one-cycle pulse: CSR file records an exception
- ex_pc  out  32  latched PC for ERA
- ex_ecode  out  6  latched ecode
- ex_esubcode  out  9  latched esubcode
- ertn_commit  out  1  one-cycle pulse: CSR file restores CRMD from PRMD
- flush_all  out  1  kill every in-flight instruction in IF..MEM
- redirect_valid  out  1  redirect_pc valid
- redirect_pc  out  32  new fetch PC
- busy  out  1  state != IDLE; WB must present no new event while high
- drop_err  out  1  sticky: an event arrived while busy

Behaviour:
- Reset (rst=0, async): state IDLE, FLUSH counter 0. Every output is 0, including ex_pc, ex_ecode, ex_esubcode, redirect_pc and drop_err.
- States and transitions:
  - IDLE: wait for an event.
  - FLUSH: flush_all=1 for FLUSH_CYCLES cycles, then go to REDIRECT.
  - REDIRECT: flush_all=1, redirect_valid=1, hold until handshake.
- Event in cycle T while IDLE:
  - If wb_ex=1: target <- csr_eentry; ex_pc/ex_ecode/ex_esubcode <- wb_pc/wb_ecode/wb_esubcode; kind=EX.
  - Else if ertn_flush=1: target <- csr_era; kind=ERTN.
  - wb_ex and ertn_flush high together: the exception wins and the ERTN is discarded.
- T+1:
  - state=FLUSH, flush_all=1, busy=1, counter=1.
  - Exactly one of ex_commit / ertn_commit pulses, for this cycle only.
- FLUSH:
  - Counter increments each cycle.
  - When counter==FLUSH_CYCLES, next state is REDIRECT.
  - Net effect: flush_all is high for FLUSH_CYCLES cycles in FLUSH.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target.
  - Both are held stable until redirect_ready=1.
  - The handshake cycle is the last cycle with flush_all/busy=1. Next cycle: IDLE, and all three of redirect_valid, flush_all and busy=0.
  - redirect_ready while not in REDIRECT is ignored.
- Event while busy: ignored, target not updated, drop_err set to 1. drop_err is cleared only by reset.
- Minimum event-to-next-event spacing is FLUSH_CYCLES+2 cycles (redirect_ready held high).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No commit pulse is replayed.
- ex_pc/ex_ecode/ex_esubcode keep their last latched value outside the commit pulse.

Optional Feature:
- Macro TRAP_CTRL_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs ex_count[31:0] and ertn_count[31:0], reset to 0.
  - Each counter increments on its commit pulse and wraps from 32'hFFFFFFFF to 0.
  - Dropped events are not counted.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header macro.h: state encodings TRAP_IDLE/TRAP_FLUSH/TRAP_REDIRECT, plus the KIND_EX/KIND_ERTN constants. The existing ECODE_* macros are reused, not redefined.
- Single module, no sub-module.
- The FLUSH counter is a 4-bit register inside trap_ctrl.

Test Plan:
- Exception:
  - Stimulus: FLUSH_CYCLES=1; wb_ex=1, wb_pc=32'h1c000010, wb_ecode=6'h0b, csr_eentry=32'h1c008000; redirect_ready=1.
  - Response: ex_commit=1 at T+1 with ex_pc=32'h1c000010, ex_ecode=6'h0b. redirect_valid=1 with redirect_pc=32'h1c008000 at T+2. IDLE at T+3.
- ERTN with stall:
  - Stimulus: ertn_flush=1, csr_era=32'h1c000014; redirect_ready held 0 for 3 cycles.
  - Response: ertn_commit pulses once. redirect_pc=32'h1c000014 is held stable for 4 cycles and drops after the handshake.
- Simultaneous events:
  - Stimulus: wb_ex=1 and ertn_flush=1 in the same cycle.
  - Response: only ex_commit pulses; redirect_pc=csr_eentry.
- Event while busy:
  - Stimulus: wb_ex during FLUSH.
  - Response: no second commit pulse, target unchanged, drop_err=1.
- Reset mid-operation:
  - Stimulus: FLUSH_CYCLES=3; rst=0 asynchronously in the 2nd FLUSH cycle.
  - Response: all outputs 0 immediately. After release, a new event is serviced normally.
- Perf counters (macro defined): 3 exceptions plus 2 ERTNs -> ex_count=3, ertn_count=2.
